s444_resp_misr: RTL and testbench
=================================

Name: s444_resp_misr

Overview:
- Downstream capture stage for the six-output s444 sequential benchmark core.
- Samples the core's 6-bit response vector {G118,G167,G107,G119,G168,G108} over a programmable window of clock cycles.
- Compacts the samples into a 16-bit MISR signature and counts response toggles.
- Presents the signature to a consumer through a valid/ready handshake. Used to compare locked and unlocked netlist behaviour across long input sequences.

Parameters:
- SEED, 16'h0000, MISR value loaded on each accepted start.
- LEN_W, 8, width of window length and sample counter.

Ports:
- CK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- start  input  1  request to begin a capture window. Accepted only in IDLE.
- len  input  LEN_W  number of samples in the window. Latched when start is accepted.
- resp_in  input  6  response vector from the core. Bit order {G118,G167,G107,G119,G168,G108}, bit5..bit0.
- busy  output  1  high in RUN and HOLD.
- sig_valid  output  1  high in HOLD; signature, toggles and samples are stable.
- sig_ready  input  1  consumer accepts the result.
- signature  output  16  MISR state.
- toggles  output  8  saturating count of samples differing from the previous sample.
- samples  output  LEN_W  number of samples taken in the current or last window.

Behaviour:
- Reset: the FSM goes to IDLE immediately. On reset:
  - signature=SEED, toggles=0, samples=0
  - busy=0, sig_valid=0
  - internal remaining count=0, previous-sample register prev=0
- RST mid-window aborts the window with no partial result held.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - On start=1 with len!=0: latch len into remaining, load signature=SEED, toggles=0, samples=0, prev=0, then go to RUN.
  - On start=1 with len==0: load the same values and go directly to HOLD (empty window).
  - Otherwise outputs keep their last values.
- RUN, on each rising edge:
  - sample resp_in; samples+=1; remaining-=1
  - MISR update: fb = sig[15]^sig[14]^sig[12]^sig[3]; sig_next = {sig[14:0],fb} ^ {10'b0,resp_in}
  - if resp_in!=prev, toggles+=1, saturating at 8'hFF; then prev=resp_in
  - on the edge where remaining goes 1->0 (the last sample), go to HOLD
- RUN timing: the first sample is taken on the edge after the start edge. There is exactly len samples and no gap cycles.
- HOLD:
  - sig_valid=1; outputs are frozen.
  - On a rising edge with sig_ready=1: go to IDLE; sig_valid drops the next cycle.
  - Outputs keep their values in IDLE until the next accepted start.
- start is ignored in RUN and HOLD; it is not queued.
- sig_ready is ignored outside HOLD.
- Handshake latency: sig_valid rises in the cycle after the last sample edge. A consumer holding sig_ready=1 completes the transfer in one cycle, so HOLD lasts at least 1 cycle.
- Back-to-back windows: the earliest next start is accepted in the first IDLE cycle after the handshake.
- The samples counter never exceeds len, so no wrap.
- The remaining counter is LEN_W bits; len=2^LEN_W-1 is the maximum window.
- resp_in is assumed synchronous to CK; no synchronizer.

Test Plan:
- Reset check: assert RST asynchronously mid-cycle, with no clock edge. Required: busy=0, sig_valid=0, signature=16'h0000, toggles=0, samples=0 immediately.
- Two-sample window: start with len=2, resp_in=6'h3F on the first sample edge, 6'h00 on the second. Required: after sample 1, signature=16'h003F; after sample 2, signature=16'h007F, toggles=2, samples=2, sig_valid=1 one cycle after the last sample edge.
- Empty window: start with len=0. Required: next cycle sig_valid=1, signature=SEED, samples=0, toggles=0; sig_ready=1 returns to IDLE.
- Backpressure and ignored start: len=3, hold sig_ready=0 for 5 cycles after sig_valid and pulse start during both RUN and HOLD. Required: outputs frozen; no new window begins; after sig_ready=1, IDLE; a following start is accepted.
- Toggle saturation: len=255 with resp_in alternating 6'h15/6'h2A. Required: toggles=8'hFF, samples=255, no wrap.
- Abort: RST asserted at sample 4 of a len=10 window. Required: IDLE, signature=SEED, no sig_valid; a following len=1 window with resp_in=6'h01 yields signature=16'h0001.

Source files
------------

// File: rtl/s444_resp_misr_if.sv
// Capture-window control, response input and signature result bundle for s444_resp_misr.
interface s444_resp_misr_if #(
  parameter int LEN_W = 8
) ();
  logic             start;
  logic [LEN_W-1:0] len;
  logic [5:0]       resp_in;
  logic             busy;
  logic             sig_valid;
  logic             sig_ready;
  logic [15:0]      signature;
  logic [7:0]       toggles;
  logic [LEN_W-1:0] samples;

  modport master (
    output start, len, resp_in, sig_ready,
    input  busy, sig_valid, signature, toggles, samples
  );

  modport slave (
    input  start, len, resp_in, sig_ready,
    output busy, sig_valid, signature, toggles, samples
  );
endinterface

// File: rtl/s444_resp_misr.sv
// Response capture for the s444 core: compacts a window of 6-bit responses into a
// 16-bit MISR signature, counts toggles, and hands the result off via valid/ready.
module s444_resp_misr #(
  parameter logic [15:0] SEED  = 16'h0000,
  parameter int          LEN_W = 8
) (
  input logic          CK,
  input logic          RST,
  s444_resp_misr_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             load, step;
  logic [LEN_W-1:0] remaining_q;
  logic [LEN_W-1:0] samples_q;
  logic [15:0]      sig_q;
  logic [7:0]       toggles_q;
  logic [5:0]       prev_q;

  // Taps 16,15,13,4 (bits 15,14,12,3); response folded into the low six bits.
  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [5:0] resp);
    logic fb;
    fb = sig[15] ^ sig[14] ^ sig[12] ^ sig[3];
    return {sig[14:0], fb} ^ {10'b0, resp};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  always_ff @(posedge CK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = (bus.len == '0) ? HOLD : RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (remaining_q == LEN_W'(1)) state_d = HOLD;
      end
      HOLD: begin
        if (bus.sig_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Window datapath: load on accepted start, one sample per RUN cycle, frozen otherwise.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      remaining_q <= '0;
      samples_q   <= '0;
      sig_q       <= SEED;
      toggles_q   <= 8'h00;
      prev_q      <= 6'h00;
    end else if (load) begin
      remaining_q <= bus.len;
      samples_q   <= '0;
      sig_q       <= SEED;
      toggles_q   <= 8'h00;
      prev_q      <= 6'h00;
    end else if (step) begin
      remaining_q <= remaining_q - LEN_W'(1);
      samples_q   <= samples_q + LEN_W'(1);
      sig_q       <= misr_step(sig_q, bus.resp_in);
      if (bus.resp_in != prev_q) toggles_q <= sat_inc(toggles_q);
      prev_q      <= bus.resp_in;
    end
  end

  assign bus.busy      = (state_q == RUN) || (state_q == HOLD);
  assign bus.sig_valid = (state_q == HOLD);
  assign bus.signature = sig_q;
  assign bus.toggles   = toggles_q;
  assign bus.samples   = samples_q;

endmodule

// File: tb/tb_s444_resp_misr.sv
// Directed bench for s444_resp_misr: table of short windows plus hand-written
// reset, empty-window, backpressure, saturation and abort sequences.
module tb_s444_resp_misr;

  logic CK;
  logic RST;
  int   checks;
  int   errors;

  s444_resp_misr_if #(.LEN_W(8)) bus ();

  s444_resp_misr #(.SEED(16'h0000), .LEN_W(8)) dut (
    .CK (CK),
    .RST(RST),
    .bus(bus)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  typedef struct {
    logic [7:0]  len;
    logic [5:0]  r0, r1, r2;
    logic [15:0] sig;
    logic [7:0]  tog;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic check_idle_clear(input string tag);
    chk({tag, "_busy"},    32'(bus.busy),      32'd0);
    chk({tag, "_valid"},   32'(bus.sig_valid), 32'd0);
    chk({tag, "_sig"},     32'(bus.signature), 32'h0000);
    chk({tag, "_toggles"}, 32'(bus.toggles),   32'd0);
    chk({tag, "_samples"}, 32'(bus.samples),   32'd0);
  endtask

  task automatic async_reset(input string tag);
    #2;
    RST = 1'b1;
    #1;
    check_idle_clear(tag);
    @(posedge CK);
    #2;
    RST = 1'b0;
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [5:0] r[3];
    r[0] = v.r0; r[1] = v.r1; r[2] = v.r2;
    bus.start = 1'b1;
    bus.len   = v.len;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < int'(v.len); i++) begin
      chk($sformatf("v%0d_busy_s%0d", idx, i), 32'(bus.busy), 32'd1);
      chk($sformatf("v%0d_novalid_s%0d", idx, i), 32'(bus.sig_valid), 32'd0);
      bus.resp_in = r[i];
      step();
    end
    chk($sformatf("v%0d_valid", idx),   32'(bus.sig_valid), 32'd1);
    chk($sformatf("v%0d_sig", idx),     32'(bus.signature), 32'(v.sig));
    chk($sformatf("v%0d_toggles", idx), 32'(bus.toggles),   32'(v.tog));
    chk($sformatf("v%0d_samples", idx), 32'(bus.samples),   32'(v.len));
    bus.sig_ready = 1'b1;
    step();
    bus.sig_ready = 1'b0;
    chk($sformatf("v%0d_idle_valid", idx), 32'(bus.sig_valid), 32'd0);
    chk($sformatf("v%0d_idle_busy", idx),  32'(bus.busy),      32'd0);
    chk($sformatf("v%0d_idle_sig", idx),   32'(bus.signature), 32'(v.sig));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{len: 8'd2, r0: 6'h3F, r1: 6'h00, r2: 6'h00, sig: 16'h007F, tog: 8'd2};
    vecs[1] = '{len: 8'd1, r0: 6'h01, r1: 6'h00, r2: 6'h00, sig: 16'h0001, tog: 8'd1};
    vecs[2] = '{len: 8'd1, r0: 6'h00, r1: 6'h00, r2: 6'h00, sig: 16'h0000, tog: 8'd0};
    vecs[3] = '{len: 8'd3, r0: 6'h01, r1: 6'h01, r2: 6'h02, sig: 16'h0004, tog: 8'd2};
    vecs[4] = '{len: 8'd3, r0: 6'h3F, r1: 6'h3F, r2: 6'h3F, sig: 16'h00BF, tog: 8'd1};
    vecs[5] = '{len: 8'd2, r0: 6'h2A, r1: 6'h15, r2: 6'h00, sig: 16'h0040, tog: 8'd2};

    RST           = 1'b1;
    bus.start     = 1'b0;
    bus.len       = 8'd0;
    bus.resp_in   = 6'h00;
    bus.sig_ready = 1'b0;
    step();
    step();
    RST = 1'b0;
    step();
    check_idle_clear("por");

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Mid-cycle asynchronous reset after a window left nonzero results.
    async_reset("rst_async");

    // Two-sample window with intermediate signature check.
    bus.start = 1'b1; bus.len = 8'd2;
    step();
    bus.start = 1'b0; bus.resp_in = 6'h3F;
    step();
    chk("two_sig1",   32'(bus.signature), 32'h003F);
    chk("two_busy1",  32'(bus.busy),      32'd1);
    chk("two_valid1", 32'(bus.sig_valid), 32'd0);
    bus.resp_in = 6'h00;
    step();
    chk("two_sig2",     32'(bus.signature), 32'h007F);
    chk("two_toggles",  32'(bus.toggles),   32'd2);
    chk("two_samples",  32'(bus.samples),   32'd2);
    chk("two_valid2",   32'(bus.sig_valid), 32'd1);
    bus.sig_ready = 1'b1;
    step();
    bus.sig_ready = 1'b0;

    // Empty window.
    bus.start = 1'b1; bus.len = 8'd0;
    step();
    bus.start = 1'b0;
    chk("empty_valid",   32'(bus.sig_valid), 32'd1);
    chk("empty_sig",     32'(bus.signature), 32'h0000);
    chk("empty_samples", 32'(bus.samples),   32'd0);
    chk("empty_toggles", 32'(bus.toggles),   32'd0);
    bus.sig_ready = 1'b1;
    step();
    bus.sig_ready = 1'b0;
    chk("empty_idle_valid", 32'(bus.sig_valid), 32'd0);
    chk("empty_idle_busy",  32'(bus.busy),      32'd0);

    // Backpressure with start pulses in RUN and HOLD.
    bus.start = 1'b1; bus.len = 8'd3;
    step();
    bus.resp_in = 6'h01; bus.len = 8'd5;
    step();
    bus.start = 1'b0; bus.resp_in = 6'h01;
    step();
    bus.start = 1'b1; bus.resp_in = 6'h02;
    step();
    for (int i = 0; i < 5; i++) begin
      bus.start = (i % 2 == 0);
      chk($sformatf("bp_valid_c%0d", i),   32'(bus.sig_valid), 32'd1);
      chk($sformatf("bp_sig_c%0d", i),     32'(bus.signature), 32'h0004);
      chk($sformatf("bp_samples_c%0d", i), 32'(bus.samples),   32'd3);
      chk($sformatf("bp_toggles_c%0d", i), 32'(bus.toggles),   32'd2);
      step();
    end
    bus.start = 1'b0;
    chk("bp_still_valid", 32'(bus.sig_valid), 32'd1);
    bus.sig_ready = 1'b1;
    step();
    bus.sig_ready = 1'b0;
    chk("bp_idle_valid", 32'(bus.sig_valid), 32'd0);
    chk("bp_idle_busy",  32'(bus.busy),      32'd0);
    chk("bp_idle_sig",   32'(bus.signature), 32'h0004);
    bus.start = 1'b1; bus.len = 8'd1;
    step();
    bus.start = 1'b0; bus.resp_in = 6'h01;
    chk("bp_next_busy", 32'(bus.busy), 32'd1);
    step();
    chk("bp_next_valid", 32'(bus.sig_valid), 32'd1);
    chk("bp_next_sig",   32'(bus.signature), 32'h0001);
    bus.sig_ready = 1'b1;
    step();
    bus.sig_ready = 1'b0;

    // Maximum window with every sample toggling.
    bus.start = 1'b1; bus.len = 8'd255;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 255; i++) begin
      bus.resp_in = (i % 2 == 0) ? 6'h15 : 6'h2A;
      step();
    end
    chk("sat_valid",   32'(bus.sig_valid), 32'd1);
    chk("sat_toggles", 32'(bus.toggles),   32'hFF);
    chk("sat_samples", 32'(bus.samples),   32'd255);
    bus.sig_ready = 1'b1;
    step();
    bus.sig_ready = 1'b0;

    // Abort a len=10 window at sample 4.
    bus.start = 1'b1; bus.len = 8'd10;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.resp_in = 6'h01 << i;
      step();
    end
    chk("abort_pre_busy", 32'(bus.busy), 32'd1);
    bus.resp_in = 6'h08;
    async_reset("abort");
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_novalid_c%0d", i), 32'(bus.sig_valid), 32'd0);
      chk($sformatf("abort_nobusy_c%0d", i),  32'(bus.busy),      32'd0);
      step();
    end
    bus.start = 1'b1; bus.len = 8'd1;
    step();
    bus.start = 1'b0; bus.resp_in = 6'h01;
    step();
    chk("abort_next_valid", 32'(bus.sig_valid), 32'd1);
    chk("abort_next_sig",   32'(bus.signature), 32'h0001);
    chk("abort_next_samp",  32'(bus.samples),   32'd1);
    bus.sig_ready = 1'b1;
    step();
    bus.sig_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
